// File: rtl/load_store_unit_if.sv
// Purpose : bundles the pipeline request/response handshakes and the data-RAM port
//           of the load/store unit into one interface.
// Latency : n/a (wiring only).
// Backpressure: n/a (wiring only); REQ_* and RSP_* are valid/ready pairs.
//
// Modports:
//   slave  - the load/store unit: consumes REQ_*, produces RSP_*, drives RAM_* controls,
//            reads RAM_DOUT and the RAM unaligned flags.
//   master - the surrounding pipeline + RAM: the mirror image of slave.
interface load_store_unit_if #(
    parameter int ADDR_W = 32
);
    // request channel
    logic              REQ_VALID;
    logic              REQ_READY;
    logic              REQ_WE;
    logic [1:0]        REQ_SIZE;
    logic              REQ_SIGNED;
    logic [ADDR_W-1:0] REQ_ADDR;
    logic [31:0]       REQ_WDATA;
    // response channel
    logic              RSP_VALID;
    logic              RSP_READY;
    logic [31:0]       RSP_RDATA;
    logic              RSP_EXC;
    logic              RSP_WE;
    // data RAM port
    logic              RAM_WE;
    logic [1:0]        RAM_RWHBS;
    logic [1:0]        RAM_WWHBS;
    logic [ADDR_W-1:0] RAM_RADDR;
    logic [ADDR_W-1:0] RAM_WADDR;
    logic [31:0]       RAM_DIN;
    logic [31:0]       RAM_DOUT;
    logic              RAM_RUNALEXC;
    logic              RAM_WUNALEXC;

    modport slave (
        input  REQ_VALID, REQ_WE, REQ_SIZE, REQ_SIGNED, REQ_ADDR, REQ_WDATA,
        output REQ_READY,
        output RSP_VALID, RSP_RDATA, RSP_EXC, RSP_WE,
        input  RSP_READY,
        output RAM_WE, RAM_RWHBS, RAM_WWHBS, RAM_RADDR, RAM_WADDR, RAM_DIN,
        input  RAM_DOUT, RAM_RUNALEXC, RAM_WUNALEXC
    );

    modport master (
        output REQ_VALID, REQ_WE, REQ_SIZE, REQ_SIGNED, REQ_ADDR, REQ_WDATA,
        input  REQ_READY,
        input  RSP_VALID, RSP_RDATA, RSP_EXC, RSP_WE,
        output RSP_READY,
        input  RAM_WE, RAM_RWHBS, RAM_WWHBS, RAM_RADDR, RAM_WADDR, RAM_DIN,
        output RAM_DOUT, RAM_RUNALEXC, RAM_WUNALEXC
    );
endinterface

// File: rtl/load_store_unit.sv
// Purpose : memory-stage sequencer in front of the byte-addressable data RAM; one
//           load/store in flight, alignment check, load sign/zero extension.
// Latency : from accept edge T -> RSP_VALID at T+1 (exception), T+2 (store), T+3 (load).
// Backpressure: REQ_READY only in IDLE; response held stable until RSP_READY, no
//           accept in the same cycle as the response handshake.
//
// Ports:
//   CLK, RST  - clock, synchronous active-high reset
//   bus       - load_store_unit_if.slave (REQ_*, RSP_*, RAM_* groups)
//   LOAD_CNT, STORE_CNT, EXC_CNT - 32-bit completed-response counters, present only
//               when LSU_PERF_CNT_EN is defined.
// Optional feature macro: LSU_PERF_CNT_EN
module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    load_store_unit_if.slave  bus
`ifdef LSU_PERF_CNT_EN
    ,
    output logic [31:0]       LOAD_CNT,
    output logic [31:0]       STORE_CNT,
    output logic [31:0]       EXC_CNT
`endif
);

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_RSVD = 2'd2;
    localparam logic [1:0] SZ_WORD = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CAPT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // request register
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_signed;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;

    // response register
    logic              r_exc;
    logic [31:0]       r_rdata;

    // combinational outputs of the FSM
    logic req_ready;
    logic rsp_valid;
    logic ram_we;

    logic accept;
    logic rsp_fire;
    logic misal;
    logic [31:0] ld_ext;

    assign accept   = bus.REQ_VALID && req_ready;
    assign rsp_fire = rsp_valid && bus.RSP_READY;

    // Alignment check is done on the live request so a bad access skips the RAM entirely.
    always_comb begin
        misal = 1'b0;
        unique case (bus.REQ_SIZE)
            SZ_WORD: misal = (bus.REQ_ADDR[1:0] != 2'b00);
            SZ_HALF: misal = bus.REQ_ADDR[0];
            SZ_RSVD: misal = 1'b1;
            default: misal = 1'b0;
        endcase
    end

    // RAM_DOUT carries the addressed byte in [7:0], so extension is purely positional.
    always_comb begin
        ld_ext = bus.RAM_DOUT;
        unique case (r_size)
            SZ_BYTE: ld_ext = {{24{r_signed & bus.RAM_DOUT[7]}}, bus.RAM_DOUT[7:0]};
            SZ_HALF: ld_ext = {{16{r_signed & bus.RAM_DOUT[15]}}, bus.RAM_DOUT[15:0]};
            default: ld_ext = bus.RAM_DOUT;
        endcase
    end

    // ---------------------------------------------------------------- FSM: state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------------- FSM: next state
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = misal ? RESP : ISSUE;
                end
            end
            ISSUE: state_nxt = r_we ? RESP : CAPT;
            CAPT:  state_nxt = RESP;
            RESP: begin
                if (bus.RSP_READY) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- FSM: outputs
    // Every handshake/strobe is gated by RST so a reset cycle is quiet even before the
    // state register has been cleared; in particular a reset during ISSUE kills the write.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        ram_we    = 1'b0;
        unique case (state)
            IDLE:  req_ready = !RST;
            ISSUE: ram_we    = r_we && !r_exc && !bus.RAM_WUNALEXC && !RST;
            RESP:  rsp_valid = !RST;
            default: ;
        endcase
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_we     <= 1'b0;
            r_size   <= 2'd0;
            r_signed <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= 32'd0;
            r_exc    <= 1'b0;
            r_rdata  <= 32'd0;
        end else begin
            if (accept) begin
                r_we     <= bus.REQ_WE;
                r_size   <= bus.REQ_SIZE;
                r_signed <= bus.REQ_SIGNED;
                r_addr   <= bus.REQ_ADDR;
                r_wdata  <= bus.REQ_WDATA;
                r_exc    <= misal;
                // Stores and exceptions answer with zero data.
                r_rdata  <= 32'd0;
            end
            // The RAM's own unaligned flags should never fire after our check; they are
            // folded in anyway so a disagreement surfaces as an exception.
            if (state == ISSUE) begin
                r_exc <= r_exc | bus.RAM_RUNALEXC | bus.RAM_WUNALEXC;
            end
            if ((state == CAPT) && !r_exc) begin
                r_rdata <= ld_ext;
            end
        end
    end

    // ---------------------------------------------------------------- output wiring
    assign bus.REQ_READY = req_ready;
    assign bus.RSP_VALID = rsp_valid;
    assign bus.RSP_RDATA = r_rdata;
    assign bus.RSP_EXC   = r_exc;
    assign bus.RSP_WE    = r_we;

    assign bus.RAM_WE    = ram_we;
    assign bus.RAM_RWHBS = r_size;
    assign bus.RAM_WWHBS = r_size;
    assign bus.RAM_RADDR = r_addr;
    assign bus.RAM_WADDR = r_addr;
    assign bus.RAM_DIN   = r_wdata;

`ifdef LSU_PERF_CNT_EN
    // One counter per completed response; natural 32-bit wrap.
    always_ff @(posedge CLK) begin
        if (RST) begin
            LOAD_CNT  <= 32'd0;
            STORE_CNT <= 32'd0;
            EXC_CNT   <= 32'd0;
        end else if (rsp_fire) begin
            if (r_exc) begin
                EXC_CNT <= EXC_CNT + 32'd1;
            end else if (r_we) begin
                STORE_CNT <= STORE_CNT + 32'd1;
            end else begin
                LOAD_CNT <= LOAD_CNT + 32'd1;
            end
        end
    end
`else
    // Without counters the response handshake has no internal consumer.
    logic unused_rsp_fire;
    assign unused_rsp_fire = rsp_fire;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Purpose : self-checking bench for load_store_unit; directed cases plus randomized
//           loads/stores against a byte-array reference memory.
// Latency : checks response latency per transaction kind.
// Backpressure: randomly stalls RSP_READY and checks response stability.
module tb_load_store_unit;

    logic CLK;
    logic RST;

    load_store_unit_if #(.ADDR_W(32)) bus ();

`ifdef LSU_PERF_CNT_EN
    logic [31:0] LOAD_CNT;
    logic [31:0] STORE_CNT;
    logic [31:0] EXC_CNT;
`endif

    load_store_unit #(.ADDR_W(32)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
`ifdef LSU_PERF_CNT_EN
        ,
        .LOAD_CNT  (LOAD_CNT),
        .STORE_CNT (STORE_CNT),
        .EXC_CNT   (EXC_CNT)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------ RAM model (device side)
    logic [7:0] ram [0:1023];

    assign bus.RAM_RUNALEXC = 1'b0;
    assign bus.RAM_WUNALEXC = 1'b0;

    always @(posedge CLK) begin
        if (bus.RAM_WE) begin
            ram[bus.RAM_WADDR[9:0]] <= bus.RAM_DIN[7:0];
            if (bus.RAM_WWHBS != 2'd0) ram[bus.RAM_WADDR[9:0] + 10'd1] <= bus.RAM_DIN[15:8];
            if (bus.RAM_WWHBS == 2'd3) begin
                ram[bus.RAM_WADDR[9:0] + 10'd2] <= bus.RAM_DIN[23:16];
                ram[bus.RAM_WADDR[9:0] + 10'd3] <= bus.RAM_DIN[31:24];
            end
        end
        bus.RAM_DOUT <= {ram[bus.RAM_RADDR[9:0] + 10'd3], ram[bus.RAM_RADDR[9:0] + 10'd2],
                         ram[bus.RAM_RADDR[9:0] + 10'd1], ram[bus.RAM_RADDR[9:0]]};
    end

    // ------------------------------------------------------------ reference model
    byte unsigned mdl [0:1023];
    int n_total = 0;
    int n_bad   = 0;
    int cnt_ld  = 0;
    int cnt_st  = 0;
    int cnt_ex  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_bad_access(input logic [1:0] sz, input int unsigned a);
        if (sz == 2'd2) return 1'b1;
        if (sz == 2'd3) return (a % 4) != 0;
        if (sz == 2'd1) return (a % 2) != 0;
        return 1'b0;
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : 4);
    endfunction

    // Little-endian value of the accessed bytes, then two's-complement reinterpretation
    // when a signed narrow load sees its top bit set.
    function automatic logic [31:0] model_load(input logic [1:0] sz, input bit sg,
                                               input int unsigned a);
        longint v;
        int n;
        n = nbytes(sz);
        v = 0;
        for (int i = n - 1; i >= 0; i--) v = v * 256 + mdl[(a + i) % 1024];
        if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic model_store(input logic [1:0] sz, input int unsigned a, input logic [31:0] wd);
        logic [31:0] d;
        d = wd;
        for (int i = 0; i < nbytes(sz); i++) begin
            mdl[(a + i) % 1024] = d[7:0];
            d = d >> 8;
        end
    endtask

    // ------------------------------------------------------------ one transaction
    // Called and returns on a negedge.
    task automatic txn(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, input int hold,
                       output logic [31:0] got);
        bit exc;
        logic [31:0] exp_d;
        int exp_lat, lat, n, we_seen, we_lat;

        exc     = is_bad_access(sz, a);
        exp_d   = (exc || we) ? 32'd0 : model_load(sz, sg, a);
        exp_lat = exc ? 1 : (we ? 2 : 3);

        bus.REQ_VALID  = 1'b1;
        bus.REQ_WE     = we;
        bus.REQ_SIZE   = sz;
        bus.REQ_SIGNED = sg;
        bus.REQ_ADDR   = a;
        bus.REQ_WDATA  = wd;
        bus.RSP_READY  = 1'b0;
        n = 0;
        while (!bus.REQ_READY && n < 10) begin
            @(negedge CLK);
            n++;
        end
        check("req_ready_idle", 32'(n < 10), 32'd1);
        @(posedge CLK);                     // accept edge T
        @(negedge CLK);
        // Scramble request inputs: the DUT must work from its latched copy.
        bus.REQ_VALID  = 1'b0;
        bus.REQ_WE     = 1'($urandom);
        bus.REQ_SIZE   = 2'($urandom);
        bus.REQ_SIGNED = 1'($urandom);
        bus.REQ_ADDR   = $urandom;
        bus.REQ_WDATA  = $urandom;

        lat = 1; we_seen = 0; we_lat = 0;
        while (!bus.RSP_VALID && lat < 8) begin
            if (bus.RAM_WE) begin
                we_seen++;
                we_lat = lat;
                check("ram_waddr", bus.RAM_WADDR, a);
                check("ram_wwhbs", 32'(bus.RAM_WWHBS), 32'(sz));
                check("ram_din", bus.RAM_DIN, wd);
            end
            if (!we && !exc) begin
                check("ram_raddr", bus.RAM_RADDR, a);
                check("ram_rwhbs", 32'(bus.RAM_RWHBS), 32'(sz));
            end
            check("req_ready_busy", 32'(bus.REQ_READY), 32'd0);
            @(negedge CLK);
            lat++;
        end
        check("rsp_latency", lat, exp_lat);
        check("ram_we_count", we_seen, (we && !exc) ? 1 : 0);
        if (we && !exc) check("ram_we_cycle", we_lat, 1);

        got = bus.RSP_RDATA;
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) @(negedge CLK);
            check("rsp_valid", 32'(bus.RSP_VALID), 32'd1);
            check("rsp_rdata", bus.RSP_RDATA, exp_d);
            check("rsp_exc", 32'(bus.RSP_EXC), 32'(exc));
            check("rsp_we", 32'(bus.RSP_WE), 32'(we));
            check("req_ready_resp", 32'(bus.REQ_READY), 32'd0);
            check("ram_we_resp", 32'(bus.RAM_WE), 32'd0);
        end
        bus.RSP_READY = 1'b1;
        @(negedge CLK);
        bus.RSP_READY = 1'b0;
        check("rsp_valid_after", 32'(bus.RSP_VALID), 32'd0);
        check("req_ready_after", 32'(bus.REQ_READY), 32'd1);

        if (exc) cnt_ex++;
        else if (we) cnt_st++;
        else cnt_ld++;
        if (we && !exc) model_store(sz, a, wd);
    endtask

    // ------------------------------------------------------------ main sequence
    initial begin
        logic [31:0] got;
        logic [1:0]  sz;
        logic [31:0] a;

        bus.REQ_VALID = 1'b0; bus.REQ_WE = 1'b0; bus.REQ_SIZE = 2'd0; bus.REQ_SIGNED = 1'b0;
        bus.REQ_ADDR = 32'd0; bus.REQ_WDATA = 32'd0; bus.RSP_READY = 1'b0;
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        check("rst_req_ready", 32'(bus.REQ_READY), 32'd0);
        check("rst_rsp_valid", 32'(bus.RSP_VALID), 32'd0);
        check("rst_ram_we", 32'(bus.RAM_WE), 32'd0);
        check("rst_rsp_rdata", bus.RSP_RDATA, 32'd0);
        check("rst_ram_waddr", bus.RAM_WADDR, 32'd0);
        RST = 1'b0;
        @(negedge CLK);
        check("idle_req_ready", 32'(bus.REQ_READY), 32'd1);

        // Give the low 256 bytes known contents in both RAM and model.
        for (int i = 0; i < 64; i++) txn(1'b1, 2'd3, 1'b0, 32'(i * 4), $urandom, 0, got);

        // Signed / unsigned byte load of 0x80.
        txn(1'b1, 2'd0, 1'b0, 32'h103, 32'hA5A5A580, 0, got);
        txn(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 0, got);
        check("tp_byte_signed", got, 32'hFFFFFF80);
        txn(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 0, got);
        check("tp_byte_unsigned", got, 32'h00000080);

        // Half store then unsigned / signed half loads.
        txn(1'b1, 2'd1, 1'b0, 32'h202, 32'h1234BEEF, 0, got);
        txn(1'b0, 2'd1, 1'b0, 32'h202, 32'h0, 0, got);
        check("tp_half_unsigned", got, 32'h0000BEEF);
        txn(1'b0, 2'd1, 1'b1, 32'h202, 32'h0, 0, got);
        check("tp_half_signed", got, 32'hFFFFBEEF);

        // Misaligned / reserved-size accesses.
        txn(1'b0, 2'd3, 1'b0, 32'h006, 32'h0, 0, got);
        txn(1'b1, 2'd3, 1'b0, 32'h001, 32'hDEADBEEF, 0, got);
        txn(1'b0, 2'd2, 1'b0, 32'h000, 32'h0, 0, got);
        txn(1'b1, 2'd1, 1'b0, 32'h203, 32'hFFFF, 0, got);

        // Backpressure on a load response.
        txn(1'b0, 2'd3, 1'b0, 32'h010, 32'h0, 5, got);

        // Reset in the ISSUE cycle of a store.
        txn(1'b1, 2'd3, 1'b0, 32'h300, 32'h11223344, 0, got);
        bus.REQ_VALID = 1'b1; bus.REQ_WE = 1'b1; bus.REQ_SIZE = 2'd3; bus.REQ_SIGNED = 1'b0;
        bus.REQ_ADDR = 32'h300; bus.REQ_WDATA = 32'hCAFEF00D;
        @(posedge CLK);
        @(negedge CLK);
        bus.REQ_VALID = 1'b0;
        check("issue_ram_we_before_rst", 32'(bus.RAM_WE), 32'd1);
        RST = 1'b1;
        #1;
        check("rst_issue_ram_we", 32'(bus.RAM_WE), 32'd0);
        check("rst_issue_rsp_valid", 32'(bus.RSP_VALID), 32'd0);
        check("rst_issue_req_ready", 32'(bus.REQ_READY), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check("post_rst_req_ready", 32'(bus.REQ_READY), 32'd1);
        check("post_rst_rsp_valid", 32'(bus.RSP_VALID), 32'd0);
        check("post_rst_rsp_we", 32'(bus.RSP_WE), 32'd0);
        check("post_rst_rsp_exc", 32'(bus.RSP_EXC), 32'd0);
        check("post_rst_rsp_rdata", bus.RSP_RDATA, 32'd0);
        check("post_rst_waddr", bus.RAM_WADDR, 32'd0);
        check("post_rst_raddr", bus.RAM_RADDR, 32'd0);
        check("post_rst_din", bus.RAM_DIN, 32'd0);
        check("post_rst_whbs", 32'(bus.RAM_WWHBS), 32'd0);
        cnt_ld = 0; cnt_st = 0; cnt_ex = 0;
`ifdef LSU_PERF_CNT_EN
        check("post_rst_load_cnt", LOAD_CNT, 32'd0);
        check("post_rst_store_cnt", STORE_CNT, 32'd0);
        check("post_rst_exc_cnt", EXC_CNT, 32'd0);
`endif
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("post_rst_no_rsp", 32'(bus.RSP_VALID), 32'd0);
        end
        // The aborted store must not have reached memory.
        txn(1'b0, 2'd3, 1'b0, 32'h300, 32'h0, 0, got);
        check("rst_store_dropped", got, 32'h11223344);
        txn(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 1, got);
        txn(1'b1, 2'd3, 1'b0, 32'h304, 32'h55667788, 0, got);
        txn(1'b0, 2'd3, 1'b0, 32'h302, 32'h0, 0, got);
`ifdef LSU_PERF_CNT_EN
        check("perf_load_cnt", LOAD_CNT, 32'd2);
        check("perf_store_cnt", STORE_CNT, 32'd1);
        check("perf_exc_cnt", EXC_CNT, 32'd1);
`endif

        // Randomized traffic inside the initialized region.
        for (int i = 0; i < 80; i++) begin
            sz = 2'($urandom_range(0, 3));
            a  = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 9) < 7) begin
                if (sz == 2'd3) a = a & 32'hFC;
                if (sz == 2'd1) a = a & 32'hFE;
            end
            txn(1'($urandom), sz, 1'($urandom), a, $urandom, int'($urandom_range(0, 3)), got);
        end

`ifdef LSU_PERF_CNT_EN
        check("perf_load_final", LOAD_CNT, cnt_ld);
        check("perf_store_final", STORE_CNT, cnt_st);
        check("perf_exc_final", EXC_CNT, cnt_ex);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-stage request sequencer that sits directly upstream of the byte-addressable data RAM.
- Accepts one load/store request at a time from the pipeline over a valid/ready handshake.
- Checks alignment, drives the RAM write/read ports and waits out the RAM's one-cycle read latency.
- Sign/zero-extends load data and returns a response, with an exception flag, over a second valid/ready handshake.

Parameters:
ADDR_W, 32, width of request and RAM address buses.

Ports:
CLK  in  1  clock; all state updates on rising edge.
RST  in  1  reset, synchronous, active-high.
REQ_VALID  in  1  request valid.
REQ_READY  out  1  request accepted when REQ_VALID&REQ_READY.
REQ_WE  in  1  1=store, 0=load.
REQ_SIZE  in  2  3=word, 1=halfword, 0=byte, 2=reserved.
REQ_SIGNED  in  1  load sign-extend (1) / zero-extend (0); ignored for word and stores.
REQ_ADDR  in  ADDR_W  byte address.
REQ_WDATA  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
RSP_VALID  out  1  response valid.
RSP_READY  in  1  response consumed when RSP_VALID&RSP_READY.
RSP_RDATA  out  32  extended load data; 0 for stores and exceptions.
RSP_EXC  out  1  unaligned or reserved-size access; no RAM write performed.
RSP_WE  out  1  echo of the latched REQ_WE.
RAM_WE  out  1  RAM write enable.
RAM_RWHBS  out  2  RAM read size code.
RAM_WWHBS  out  2  RAM write size code.
RAM_RADDR  out  ADDR_W  RAM read address.
RAM_WADDR  out  ADDR_W  RAM write address.
RAM_DIN  out  32  RAM write data (REQ_WDATA passed unmodified).
RAM_DOUT  in  32  RAM read data, addressed byte in [7:0], valid the cycle after RAM_RADDR is presented.
RAM_RUNALEXC  in  1  RAM read-unaligned flag.
RAM_WUNALEXC  in  1  RAM write-unaligned flag.

Behaviour:
- Request register latches WE/SIZE/SIGNED/ADDR/WDATA on accept. RAM_RADDR, RAM_WADDR, RAM_DIN, RAM_RWHBS and RAM_WWHBS are driven continuously from this register.
- FSM states: IDLE, ISSUE, CAPT, RESP.
- IDLE: REQ_READY=1 (0 while RST=1). On accept:
  - misaligned (word with ADDR[1:0]!=0; half with ADDR[0]=1; SIZE=2) -> RESP with EXC=1;
  - otherwise -> ISSUE.
- ISSUE (1 cycle):
  - store: RAM_WE=1 for exactly this cycle, then -> RESP;
  - load: -> CAPT.
  - RAM_RUNALEXC/RAM_WUNALEXC sampled here and ORed into EXC (defensive).
- CAPT (1 cycle): RAM_DOUT is extended per size/signed and latched into the response data register; -> RESP.
  - byte signed: {24{d[7]}},d[7:0]; byte unsigned: zero-fill.
  - half signed: {16{d[15]}},d[15:0]; half unsigned: zero-fill.
  - word: d.
- RESP: RSP_VALID=1 with RSP_RDATA/RSP_EXC/RSP_WE held stable until RSP_READY. On handshake -> IDLE.
- No accept in the same cycle as a response handshake.
- Latency from the accept edge T:
  - store: RAM_WE in T+1, RSP_VALID from T+2;
  - load: RADDR held from T+1, RSP_VALID from T+3;
  - exception: RSP_VALID from T+1.
- Peak throughput: one load per 4 cycles, one store per 3.
- RAM_WE is 0 in every state except ISSUE with a store and no exception. RAM_WE is gated by !RST, so a reset asserted during ISSUE suppresses the write in that same cycle.
- Reset (synchronous): state=IDLE; RSP_VALID, RSP_EXC, RSP_WE, RAM_WE = 0; RSP_RDATA = 0; request register = 0 (RAM_* address/data/size outputs = 0). Reset mid-operation drops the in-flight request and issues no response.

Optional Feature:
LSU_PERF_CNT_EN:
- Defined: adds outputs LOAD_CNT, STORE_CNT, EXC_CNT (each 32, out).
  - On each response handshake, exactly one counter increments: EXC_CNT if RSP_EXC, else STORE_CNT if RSP_WE, else LOAD_CNT.
  - Counters wrap 0xFFFFFFFF->0 and reset to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Byte 0x80 preloaded at 0x103; load, SIZE=0, SIGNED=1, ADDR=0x103 -> RAM_RADDR=0x103 from T+1, RSP_VALID at T+3, RSP_RDATA=0xFFFFFF80, EXC=0. Same load with SIGNED=0 -> 0x00000080.
- Store, SIZE=1, ADDR=0x202, WDATA=0x1234BEEF -> RAM_WE=1 only in T+1, WADDR=0x202, WWHBS=1, DIN=0x1234BEEF, RSP_VALID at T+2, RSP_WE=1. Then half unsigned load from 0x202 -> 0x0000BEEF.
- Misalignment: word load at 0x006 -> RSP_VALID at T+1, RSP_EXC=1, RSP_RDATA=0, RAM_WE never asserted. Word store at 0x001 and SIZE=2 at 0x000 -> same.
- Backpressure: hold RSP_READY=0 for 5 cycles during a load response -> RSP_* stable, REQ_READY=0 throughout. Raise RSP_READY -> IDLE next cycle, REQ_READY=1.
- Reset mid-store: assert RST in the ISSUE cycle -> RAM_WE=0 in that cycle, FSM in IDLE after the edge, no RSP_VALID, all outputs at reset values.
- With LSU_PERF_CNT_EN: 2 loads, 1 store, 1 misaligned -> LOAD_CNT=2, STORE_CNT=1, EXC_CNT=1.
